// File: rtl/rect_pkg.sv
// Shared constants, FSM states and word/address helpers for the
// Rectilinearizer edge pipeline.
package rect_pkg;

    localparam int ADDR_W   = 19;
    localparam int WORD_W   = 36;
    localparam int LUMA_MSB = 29;
    localparam int LUMA_LSB = 20;
    localparam int LUMA_W   = LUMA_MSB - LUMA_LSB + 1;

    localparam logic [LUMA_W-1:0] CHROMA_NEUTRAL = 10'd512;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH0,
        S_FETCH1,
        S_FETCH2,
        S_WAIT1,
        S_WAIT2,
        S_SHIFT,
        S_CALC,
        S_WRITE
    } sobel_state_t;

    function automatic logic [WORD_W-1:0] pack_gray(
        input logic [LUMA_W-1:0] mag
    );
        return {6'b0, mag, CHROMA_NEUTRAL, CHROMA_NEUTRAL};
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [9:0] x,
        input logic [8:0] y
    );
        return {y, x};
    endfunction

endpackage

// File: rtl/sobel_kernel.sv
// 3x3 luma window with Sobel |Gx|+|Gy| magnitude, registered on calc.
// SOBEL_THRESHOLD_EN turns the magnitude into a 0/1023 binary edge map.
module sobel_kernel
    import rect_pkg::*;
#(
    parameter int THRESHOLD = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_clear,
    input  logic                   i_shift,
    input  logic [2:0][LUMA_W-1:0] i_col,
    input  logic                   i_calc,
    input  logic                   i_border,
    output logic [LUMA_W-1:0]      o_mag
);

`ifdef SOBEL_THRESHOLD_EN
    localparam bit BIN = 1'b1;
`else
    localparam bit BIN = 1'b0;
`endif

    logic [8:0][LUMA_W-1:0] r_win;
    logic [LUMA_W-1:0]      r_mag;
    logic signed [12:0]     w_gx;
    logic signed [12:0]     w_gy;
    logic [12:0]            w_ax;
    logic [12:0]            w_ay;
    logic [12:0]            w_sum;
    logic [LUMA_W-1:0]      w_mag;

    function automatic logic [12:0] tap(
        input logic [LUMA_W-1:0] a,
        input logic [LUMA_W-1:0] b,
        input logic [LUMA_W-1:0] c
    );
        return 13'(a) + 13'({b, 1'b0}) + 13'(c);
    endfunction

    // Window index: p0 p1 p2 / p3 p4 p5 / p6 p7 p8, rows y-1..y+1
    assign w_gx = signed'(tap(r_win[2], r_win[5], r_win[8])
                        - tap(r_win[0], r_win[3], r_win[6]));
    assign w_gy = signed'(tap(r_win[6], r_win[7], r_win[8])
                        - tap(r_win[0], r_win[1], r_win[2]));

    assign w_ax  = w_gx[12] ? unsigned'(-w_gx) : unsigned'(w_gx);
    assign w_ay  = w_gy[12] ? unsigned'(-w_gy) : unsigned'(w_gy);
    assign w_sum = w_ax + w_ay;

    always_comb begin
        w_mag = '0;
        if (BIN)
            w_mag = (w_sum >= 13'(THRESHOLD)) ? '1 : '0;
        else
            w_mag = (w_sum > 13'd1023) ? '1 : w_sum[LUMA_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win <= '0;
            r_mag <= '0;
        end else begin
            if (i_clear) begin
                r_win <= '0;
            end else if (i_shift) begin
                r_win[0] <= r_win[1];
                r_win[1] <= r_win[2];
                r_win[2] <= i_col[0];
                r_win[3] <= r_win[4];
                r_win[4] <= r_win[5];
                r_win[5] <= i_col[1];
                r_win[6] <= r_win[7];
                r_win[7] <= r_win[8];
                r_win[8] <= i_col[2];
            end
            if (i_calc)
                r_mag <= i_border ? '0 : w_mag;
        end
    end

    assign o_mag = r_mag;

endmodule

// File: rtl/sobel_edge_detector.sv
// Sobel stage: column-wise 3x3 fetch from frame memory, magnitude write-back.
// Build with SOBEL_THRESHOLD_EN defined for binarised output at THRESHOLD.
module sobel_edge_detector
    import rect_pkg::*;
#(
    parameter int WIDTH     = 640,
    parameter int HEIGHT    = 480,
    parameter int THRESHOLD = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [WORD_W-1:0] read_data,
    output logic [ADDR_W-1:0] write_addr,
    output logic [WORD_W-1:0] write_data,
    output logic              write_enable
);

    localparam logic [10:0] C_LAST = 11'(WIDTH);
    localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);

    sobel_state_t           r_state;
    sobel_state_t           w_next;
    logic [10:0]            r_c;
    logic [8:0]             r_y;
    logic                   r_done;
    logic [2:0][LUMA_W-1:0] r_col;
    logic [LUMA_W-1:0]      w_fill;
    logic [LUMA_W-1:0]      w_mag;
    logic [8:0]             w_ym1;
    logic [8:0]             w_yp1;
    logic                   w_last_col;
    logic                   w_border;
    logic                   w_unused;

    assign w_last_col = (r_c == C_LAST);
    assign w_ym1      = (r_y == 9'd0) ? 9'd0 : r_y - 9'd1;
    assign w_yp1      = (r_y == Y_LAST) ? r_y : r_y + 9'd1;
    assign w_fill     = w_last_col ? '0 : read_data[LUMA_MSB:LUMA_LSB];
    assign w_border   = (r_c == 11'd1) || w_last_col ||
                        (r_y == 9'd0) || (r_y == Y_LAST);
    assign w_unused   = ^{read_data[WORD_W-1:LUMA_MSB+1],
                          read_data[LUMA_LSB-1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (start) begin
            w_next = S_FETCH0;
        end else begin
            unique case (r_state)
                S_IDLE:   w_next = S_IDLE;
                S_FETCH0: w_next = S_FETCH1;
                S_FETCH1: w_next = S_FETCH2;
                S_FETCH2: w_next = S_WAIT1;
                S_WAIT1:  w_next = S_WAIT2;
                S_WAIT2:  w_next = S_SHIFT;
                S_SHIFT:  w_next = (r_c == 11'd0) ? S_FETCH0 : S_CALC;
                S_CALC:   w_next = S_WRITE;
                S_WRITE:  w_next = (w_last_col && r_y == Y_LAST)
                                   ? S_IDLE : S_FETCH0;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c    <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_WRITE) && w_last_col &&
                      (r_y == Y_LAST) && !start;
            if (start) begin
                r_c <= '0;
                r_y <= '0;
            end else if (r_state == S_SHIFT && r_c == 11'd0) begin
                r_c <= 11'd1;
            end else if (r_state == S_WRITE) begin
                if (w_last_col) begin
                    r_c <= '0;
                    if (r_y != Y_LAST)
                        r_y <= r_y + 9'd1;
                end else begin
                    r_c <= r_c + 11'd1;
                end
            end
        end
    end

    // Column luma lands two cycles after each fetch address
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_col <= '0;
        end else begin
            case (r_state)
                S_FETCH2: r_col[0] <= w_fill;
                S_WAIT1:  r_col[1] <= w_fill;
                S_WAIT2:  r_col[2] <= w_fill;
                default:  ;
            endcase
        end
    end

    always_comb begin
        read_addr = '0;
        if (!w_last_col) begin
            case (r_state)
                S_FETCH0: read_addr = pix_addr(r_c[9:0], w_ym1);
                S_FETCH1: read_addr = pix_addr(r_c[9:0], r_y);
                S_FETCH2: read_addr = pix_addr(r_c[9:0], w_yp1);
                default:  read_addr = '0;
            endcase
        end
    end

    sobel_kernel #(
        .THRESHOLD(THRESHOLD)
    ) u_kernel (
        .clk     (clk),
        .reset   (reset),
        .i_clear (start),
        .i_shift (r_state == S_SHIFT),
        .i_col   ({r_col[2], r_col[1], r_col[0]}),
        .i_calc  (r_state == S_CALC),
        .i_border(w_border),
        .o_mag   (w_mag)
    );

    assign write_enable = (r_state == S_WRITE);
    assign write_addr   = write_enable
                        ? pix_addr(10'(r_c - 11'd1), r_y) : '0;
    assign write_data   = write_enable ? pack_gray(w_mag) : '0;
    assign done         = r_done;
    assign busy         = (r_state != S_IDLE);

endmodule

// File: doc/sobel_edge_detector.md
# sobel_edge_detector

Second stage of the Rectilinearizer edge pipeline. Consumes the blurred grayscale frame the Gaussian stage leaves in frame memory: 36-bit YCrCb words, luma in bits [29:20]. Computes a 3x3 Sobel gradient magnitude per pixel and writes it back as a grayscale YCrCb frame to a separate output region. Runs once per `start` pulse and signals completion with a one-cycle `done`.

## Interface
Parameters:
- `WIDTH`, default 640: frame width in pixels, at most 1024.
- `HEIGHT`, default 480: frame height in pixels, at most 512.
- `THRESHOLD`, default 256: binarisation level, used only when `SOBEL_THRESHOLD_EN` is defined.

Ports:
- `clk`, input, 1: single clock for the whole block.
- `reset`, input, 1: reset is asynchronous and active-high.
- `start`, input, 1: one-cycle pulse that begins a frame.
- `done`, output, 1: one-cycle pulse after the last write of a frame.
- `busy`, output, 1: high while a frame is being processed.
- `read_addr`, output, 19: source address `{y[8:0], x[9:0]}`.
- `read_data`, input, 36: source word. Returns 2 cycles after its `read_addr` is presented.
- `write_addr`, output, 19: destination address `{y[8:0], x[9:0]}`.
- `write_data`, output, 36: `{6'b0, mag[9:0], 10'd512, 10'd512}`.
- `write_enable`, output, 1: one-cycle strobe qualifying `write_addr` and `write_data`.

## Operation
- States:
  - IDLE
  - FETCH0, FETCH1, FETCH2: issue reads for rows y-1, y, y+1 of column c.
  - WAIT: 2 cycles.
  - SHIFT: the 3x3 window shifts left and column c enters on the right.
  - CALC: registers the magnitude.
  - WRITE
- Column loop, per line y: c = 0..WIDTH.
  - For c < WIDTH, fetch column c.
  - For c = WIDTH, no reads; shift in zeros.
  - For c >= 1, the window centre is pixel (c-1, y); WRITE emits that pixel.
  - The iteration for c = 0 skips CALC and WRITE: FETCH0..2, WAIT, SHIFT, then FETCH0.
- Row addresses are clamped to [0, HEIGHT-1]. Luma is captured in the cycle the data returns: FETCH2, WAIT1, WAIT2.
- Arithmetic:
  - Gx = (p2 + 2·p5 + p8) - (p0 + 2·p3 + p6).
  - Gy = (p6 + 2·p7 + p8) - (p0 + 2·p1 + p2).
  - Each is 13-bit signed. |Gx|+|Gy| is 13-bit unsigned and saturates to 1023 for `mag`.
- Border pixels get mag = 0: x = 0, x = WIDTH-1, y = 0 or y = HEIGHT-1.
- After WRITE of pixel (WIDTH-1, HEIGHT-1), go to IDLE and pulse `done`.
- `start` in any state, including mid-frame, restarts at (0,0) with the window cleared. No `done` is produced for the aborted frame.
- `reset` in any state, including mid-frame, forces IDLE immediately. No `done`, no write.

## Timing
- Reset values are 0 for every output: `done`, `busy`, `read_addr`, `write_addr`, `write_data` and `write_enable`.
- Cycle cost:
  - 8 cycles per output pixel: FETCH0..2, WAIT×2, SHIFT, CALC, WRITE.
  - 6 cycles for the c = 0 column of each line.
- Total frame = HEIGHT·(8·WIDTH + 6) cycles from the first FETCH0.
- `busy` rises the cycle after `start` and falls in the same cycle `done` is high.
- `write_enable` is high exactly once per pixel, WIDTH·HEIGHT times per frame, in raster order.
- `done` is asserted the cycle after the final WRITE.

## Configuration
- `SOBEL_THRESHOLD_EN` defined: mag = (|Gx|+|Gy| >= THRESHOLD) ? 1023 : 0. Border pixels are still 0.
- Not defined: mag is the saturated magnitude and `THRESHOLD` is unused.

## Structure
- Shared package `rect_pkg` holds:
  - `ADDR_W` = 19, `WORD_W` = 36, `LUMA_MSB` = 29, `LUMA_LSB` = 20, `CHROMA_NEUTRAL` = 10'd512.
  - A `pack_gray` function building the output word.
  - A `pix_addr(x, y)` function.
- Sub-module `sobel_kernel` holds the 3x3 window registers, the shift, and the Gx/Gy/abs/saturate/threshold logic. The parent keeps the FSM, counters and memory ports.

## Test plan
All scenarios use WIDTH=8, HEIGHT=6 and a behavioural 2-cycle-latency memory model.
- Uniform frame, luma 300 everywhere, then `start` → 48 writes, all `write_data` = {6'b0, 10'd0, 10'd512, 10'd512}; `done` at cycle 6·(8·8+6) after the first FETCH0.
- Vertical step, luma 0 for x<4 and 100 for x>=4 → interior pixels at x=3 and x=4 get mag 400; other interior pixels 0; all borders 0.
- Horizontal step from 0 to 1023 at y=3 → |Gy| = 4092, so interior pixels at y=2 and y=3 get mag saturated to 1023.
- `SOBEL_THRESHOLD_EN` with THRESHOLD=256 on the vertical step → x=3,4 interior pixels get 1023, all others 0.
- `start` pulsed mid-frame at pixel (3,2) → writes restart at address pix_addr(0,0); exactly one `done`, after a full frame.
- `reset` asserted mid-frame → all outputs 0 the same cycle; no `write_enable` and no `done` until the next `start`.
